// File: rtl/sysmgr_rst_seq_pkg.sv
// Shared definitions for the system-manager reset sequencer: FSM encoding and
// a constant clog2 used to size the counters.
package sysmgr_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/sysmgr_rst_seq_if.sv
// Lock input, software request and reset/status outputs of the reset sequencer.
interface sysmgr_rst_seq_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             sw_rst_req;
    logic [N_CH-1:0]  rst_out;
    logic             ready;
    logic             locked;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (
        output pll_lock, sw_rst_req,
        input  rst_out, ready, locked, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, sw_rst_req,
        output rst_out, ready, locked, lock_loss_cnt
    );
endinterface

// File: rtl/sysmgr_rst_seq_lock_filt.sv
// Two-flop synchroniser for the asynchronous PLL lock plus a saturating
// run-length filter that declares lock after LOCK_FILT consecutive high cycles.
module sysmgr_lock_filt
    import sysmgr_pkg::*;
#(
    parameter int LOCK_FILT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    output logic lock_s,
    output logic locked
);
    localparam int                FILT_W   = clog2(LOCK_FILT + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);

    logic              sync_p0;
    logic [FILT_W-1:0] filt_cnt;
    logic [FILT_W-1:0] filt_nxt;

    always_comb begin
        filt_nxt = filt_cnt;
        if (!lock_s) begin
            filt_nxt = '0;
        end else if (filt_cnt != FILT_MAX) begin
            filt_nxt = filt_cnt + 1'b1;
        end
    end

    // locked is registered from the next count so it rises on the same edge
    // the counter reaches LOCK_FILT.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            lock_s   <= 1'b0;
            filt_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            sync_p0  <= pll_lock;
            lock_s   <= sync_p0;
            filt_cnt <= filt_nxt;
            locked   <= (filt_nxt == FILT_MAX);
        end
    end

endmodule

// File: rtl/sysmgr_rst_seq.sv
// Reset sequencer: waits for a filtered PLL lock, then releases N_CH resets in
// order, HOLD cycles apart; lock loss or a software request restarts it.
module sysmgr_rst_seq
    import sysmgr_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int HOLD      = 8,
    parameter int LOCK_FILT = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    sysmgr_rst_seq_if.slave  bus
);
    localparam int                HOLD_W    = clog2(HOLD);
    localparam int                IDX_W     = clog2(N_CH + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]   CH_ONE    = N_CH'(1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [N_CH-1:0]   rst_out_q;
    logic              ready_q;
    logic [CNT_W-1:0]  loss_cnt;
    logic              lock_s;
    logic              locked;

    sysmgr_lock_filt #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_filt (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (bus.pll_lock),
        .lock_s   (lock_s),
        .locked   (locked)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WAIT;
            hold_cnt  <= '0;
            ch_idx    <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            loss_cnt  <= '0;
        end else if (state == ST_WAIT) begin
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            if (locked) begin
                state    <= ST_SEQ;
                hold_cnt <= '0;
                ch_idx   <= '0;
            end
        end else if (!lock_s) begin
            // Lock dropped while sequencing or running: back to WAIT, count it.
            state     <= ST_WAIT;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            if (loss_cnt != '1) begin
                loss_cnt <= loss_cnt + 1'b1;
            end
        end else if (bus.sw_rst_req) begin
            // Restart the release sequence without re-running the lock filter.
            state     <= ST_SEQ;
            hold_cnt  <= '0;
            ch_idx    <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else if (state == ST_SEQ) begin
            if (hold_cnt == HOLD_LAST) begin
                rst_out_q <= rst_out_q & ~(CH_ONE << ch_idx);
                hold_cnt  <= '0;
                ch_idx    <= ch_idx + 1'b1;
                if (ch_idx == IDX_LAST) begin
                    state   <= ST_RUN;
                    ready_q <= 1'b1;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end else begin
            rst_out_q <= '0;
            ready_q   <= 1'b1;
        end
    end

    assign bus.rst_out       = rst_out_q;
    assign bus.ready         = ready_q;
    assign bus.locked        = locked;
    assign bus.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Bench for sysmgr_rst_seq: directed timeline table, hand-written corner
// sequences and a randomized run, all checked against an elapsed-time model.
module tb_sysmgr_rst_seq;
    localparam int N_CH      = 3;
    localparam int HOLD      = 8;
    localparam int LOCK_FILT = 16;
    localparam int CNT_A     = 8;
    localparam int CNT_B     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sysmgr_rst_seq_if #(.N_CH(N_CH), .CNT_W(CNT_A)) bus_a ();
    sysmgr_rst_seq_if #(.N_CH(N_CH), .CNT_W(CNT_B)) bus_b ();

    sysmgr_rst_seq #(.N_CH(N_CH), .HOLD(HOLD), .LOCK_FILT(LOCK_FILT), .CNT_W(CNT_A)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    sysmgr_rst_seq #(.N_CH(N_CH), .HOLD(HOLD), .LOCK_FILT(LOCK_FILT), .CNT_W(CNT_B)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: lock history, consecutive-high run length and time since
    // the release sequence (re)started; releases follow from elapsed time.
    bit [1:0] m_sync;
    int       m_run;
    bit       m_locked;
    bit       m_active;
    int       m_t;
    int       m_loss;

    typedef struct {
        int             k;
        logic           pll;
        logic [N_CH-1:0] exp_rst;
        logic           exp_rdy;
        logic           exp_lk;
    } nom_t;

    nom_t nom [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic void model_edge(input bit p, input bit s, input bit r);
        bit ls;
        ls = m_sync[1];
        if (r) begin
            m_sync = 2'b00; m_run = 0; m_locked = 1'b0;
            m_active = 1'b0; m_t = 0; m_loss = 0;
            return;
        end
        if (!m_active) begin
            if (m_locked) begin
                m_active = 1'b1;
                m_t = 0;
            end
        end else if (!ls) begin
            m_active = 1'b0;
            m_loss++;
        end else if (s) begin
            m_t = 0;
        end else if (m_t < HOLD * N_CH) begin
            m_t++;
        end
        m_run    = ls ? ((m_run < LOCK_FILT) ? m_run + 1 : LOCK_FILT) : 0;
        m_locked = (m_run == LOCK_FILT);
        m_sync   = {m_sync[0], p};
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic tick(input bit p, input bit s, input bit r);
        int rel;
        logic [N_CH-1:0] e_rst;
        bus_a.pll_lock = p; bus_a.sw_rst_req = s;
        bus_b.pll_lock = p; bus_b.sw_rst_req = s;
        rst = r;
        @(posedge clk);
        model_edge(p, s, r);
        #1;
        rel   = m_active ? m_t / HOLD : 0;
        e_rst = m_active ? N_CH'(((1 << N_CH) - 1) & ~((1 << rel) - 1)) : '1;
        chk("model_rst_out", 32'(bus_a.rst_out), 32'(e_rst));
        chk("model_ready", 32'(bus_a.ready), 32'(m_active && rel == N_CH));
        chk("model_locked", 32'(bus_a.locked), 32'(m_locked));
        chk("model_loss_cnt", 32'(bus_a.lock_loss_cnt), 32'(sat(m_loss, CNT_A)));
        chk("model_loss_cnt_sat", 32'(bus_b.lock_loss_cnt), 32'(sat(m_loss, CNT_B)));
    endtask

    task automatic run_nominal(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            while (n <= nom[i].k) begin
                tick(nom[i].pll, 1'b0, 1'b0);
                n++;
            end
            chk({tag, "_rst_out"}, 32'(bus_a.rst_out), 32'(nom[i].exp_rst));
            chk({tag, "_ready"}, 32'(bus_a.ready), 32'(nom[i].exp_rdy));
            chk({tag, "_locked"}, 32'(bus_a.locked), 32'(nom[i].exp_lk));
        end
    endtask

    initial begin
        int remain;
        bit p;

        nom[0] = '{k: 16, pll: 1'b1, exp_rst: 3'b111, exp_rdy: 1'b0, exp_lk: 1'b0};
        nom[1] = '{k: 17, pll: 1'b1, exp_rst: 3'b111, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[2] = '{k: 25, pll: 1'b1, exp_rst: 3'b111, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[3] = '{k: 26, pll: 1'b1, exp_rst: 3'b110, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[4] = '{k: 33, pll: 1'b1, exp_rst: 3'b110, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[5] = '{k: 34, pll: 1'b1, exp_rst: 3'b100, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[6] = '{k: 41, pll: 1'b1, exp_rst: 3'b100, exp_rdy: 1'b0, exp_lk: 1'b1};
        nom[7] = '{k: 42, pll: 1'b1, exp_rst: 3'b000, exp_rdy: 1'b1, exp_lk: 1'b1};
        nom[8] = '{k: 50, pll: 1'b1, exp_rst: 3'b000, exp_rdy: 1'b1, exp_lk: 1'b1};

        bus_a.pll_lock = 1'b0; bus_a.sw_rst_req = 1'b0;
        bus_b.pll_lock = 1'b0; bus_b.sw_rst_req = 1'b0;

        // Power-up: reset with lock low, then stay idle.
        repeat (4) tick(1'b0, 1'b0, 1'b1);
        chk("por_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("por_ready", 32'(bus_a.ready), 32'h0);
        chk("por_locked", 32'(bus_a.locked), 32'h0);
        chk("por_loss_cnt", 32'(bus_a.lock_loss_cnt), 32'h0);
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        chk("idle_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("idle_ready", 32'(bus_a.ready), 32'h0);

        run_nominal("nominal");

        // Glitchy lock: 10 high, 1 low (edge G), then high.
        tick(1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 27; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (k <= 26) chk("glitch_hold", 32'(bus_a.rst_out), 32'h7);
            if (k == 17) chk("glitch_unlocked", 32'(bus_a.locked), 32'h0);
            if (k == 18) chk("glitch_locked", 32'(bus_a.locked), 32'h1);
        end
        chk("glitch_first_rel", 32'(bus_a.rst_out), 32'h6);
        chk("glitch_loss_cnt", 32'(bus_a.lock_loss_cnt), 32'h0);
        repeat (18) tick(1'b1, 1'b0, 1'b0);
        chk("glitch_run_ready", 32'(bus_a.ready), 32'h1);

        // Lock loss in RUN, then the nominal timeline again.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("loss_d1_ready", 32'(bus_a.ready), 32'h1);
        tick(1'b0, 1'b0, 1'b0);
        chk("loss_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("loss_ready", 32'(bus_a.ready), 32'h0);
        chk("loss_cnt", 32'(bus_a.lock_loss_cnt), 32'h1);
        tick(1'b0, 1'b0, 1'b0);
        run_nominal("relock");

        // Software request in RUN.
        tick(1'b1, 1'b1, 1'b0);
        chk("sw_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("sw_ready", 32'(bus_a.ready), 32'h0);
        for (int k = 1; k <= 24; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            chk("sw_locked", 32'(bus_a.locked), 32'h1);
            if (k == 7)  chk("sw_pre_rel0", 32'(bus_a.rst_out), 32'h7);
            if (k == 8)  chk("sw_rel0", 32'(bus_a.rst_out), 32'h6);
            if (k == 16) chk("sw_rel1", 32'(bus_a.rst_out), 32'h4);
        end
        chk("sw_rel2", 32'(bus_a.rst_out), 32'h0);
        chk("sw_run_ready", 32'(bus_a.ready), 32'h1);

        // Software request in the cycle lock_s falls: lock loss wins.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("prio_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("prio_loss_cnt", 32'(bus_a.lock_loss_cnt), 32'h2);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk("prio_wait_cnt", 32'(bus_a.lock_loss_cnt), 32'h2);
        chk("prio_wait_rst", 32'(bus_a.rst_out), 32'h7);

        // Repeated losses: 2-bit counter saturates at 3.
        for (int l = 1; l <= 5; l++) begin
            repeat (22) tick(1'b1, 1'b0, 1'b0);
            repeat (4) tick(1'b0, 1'b0, 1'b0);
            chk("sat_cnt2", 32'(bus_b.lock_loss_cnt), 32'((2 + l > 3) ? 3 : 2 + l));
            chk("sat_cnt8", 32'(bus_a.lock_loss_cnt), 32'(2 + l));
        end

        // rst mid-sequence.
        repeat (31) tick(1'b1, 1'b0, 1'b0);
        chk("midseq_rst_out", 32'(bus_a.rst_out), 32'h6);
        tick(1'b1, 1'b0, 1'b1);
        chk("rst_rst_out", 32'(bus_a.rst_out), 32'h7);
        chk("rst_ready", 32'(bus_a.ready), 32'h0);
        chk("rst_locked", 32'(bus_a.locked), 32'h0);
        chk("rst_cnt", 32'(bus_a.lock_loss_cnt), 32'h0);
        chk("rst_cnt_sat", 32'(bus_b.lock_loss_cnt), 32'h0);
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_after_locked", 32'(bus_a.locked), 32'h0);

        // Randomized lock/request/reset activity.
        remain = 0;
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (remain == 0) begin
                p = !p;
                remain = p ? int'($urandom_range(90, 1)) : int'($urandom_range(10, 1));
            end
            remain--;
            tick(p, $urandom_range(63, 0) == 0, $urandom_range(599, 0) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sysmgr_rst_seq.md
Name: sysmgr_rst_seq

Overview:
Parametrised reset sequencer for the system manager. It synchronises and debounces a PLL lock indication and releases N_CH reset outputs one after another, with a fixed hold interval between releases. Loss of lock re-asserts every reset. A software request re-runs the release sequence. It sits after the PLL in the system manager and generalises the single fixed-count logic reset into multiple ordered reset channels with lock filtering and fault counting.

Parameters:
N_CH, 3, number of reset channels released in order (1..16)
HOLD, 8, cycles between entering the sequence and each successive release (>=2)
LOCK_FILT, 16, consecutive synchronised-high lock cycles required before sequencing (>=1)
CNT_W, 8, width of the saturating lock-loss counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pll_lock  in  1  asynchronous PLL lock indication
sw_rst_req  in  1  single-cycle software reset request
rst_out  out  N_CH  per-channel active-high resets; bit 0 released first
ready  out  1  high when every channel is released (RUN state)
locked  out  1  filtered lock status (filter count == LOCK_FILT)
lock_loss_cnt  out  CNT_W  saturating count of lock losses seen in SEQ or RUN

Behaviour:
- One clock; reset is synchronous and active-high. rst clears the 2-FF synchroniser, filt_cnt, hold_cnt and ch_idx, and forces state WAIT.
- Reset values: rst_out = all ones, ready = 0, locked = 0, lock_loss_cnt = 0.
- Synchroniser: two flops on pll_lock give lock_s. A pll_lock high sampled at edge E gives lock_s = 1 after edge E+1.
- Filter: filt_cnt width is clog2(LOCK_FILT+1). If lock_s = 0, filt_cnt clears. Otherwise it increments until it reaches LOCK_FILT, then holds. locked = (filt_cnt == LOCK_FILT), registered.
- FSM states: WAIT, SEQ, RUN (constants in the package).
  - WAIT: rst_out = all ones, ready = 0. When locked = 1, go to SEQ with hold_cnt = 0 and ch_idx = 0.
  - SEQ: hold_cnt increments each cycle. When hold_cnt == HOLD-1:
    - clear rst_out[ch_idx], set hold_cnt = 0, increment ch_idx;
    - if ch_idx == N_CH-1, go to RUN and set ready = 1 on that same edge.
  - RUN: rst_out = all zeros, ready = 1. Stays in RUN until a lock loss or a software request.
- Lock loss: lock_s = 0 while in SEQ or RUN.
  - Next edge: go to WAIT, rst_out = all ones, ready = 0.
  - lock_loss_cnt increments and saturates at all ones.
  - Lock loss in WAIT is not counted.
- Software request: sw_rst_req = 1 in SEQ or RUN with lock_s = 1.
  - Next edge: rst_out = all ones, ready = 0, go to SEQ with hold_cnt = 0 and ch_idx = 0. The filter is not re-run.
  - Ignored in WAIT.
- Priority: rst > lock loss > sw_rst_req > normal sequencing.
- Latency: from entering SEQ, channel k releases after HOLD*(k+1) edges.
- Invariant: releases are monotonic; rst_out[j] = 0 implies rst_out[i] = 0 for all i < j.

Decomposition:
- Package sysmgr_pkg: FSM state encoding (WAIT/SEQ/RUN) and a clog2 helper constant function.
- One sub-module is natural: sysmgr_lock_filt, containing the 2-FF synchroniser and the filter counter, with outputs lock_s and locked. The FSM, the counters and rst_out stay in the top.

Test Plan:
- Power-up: hold rst for 4 cycles with pll_lock = 0 -> rst_out = 3'b111, ready = 0, locked = 0, lock_loss_cnt = 0. These must hold indefinitely while pll_lock stays low.
- Nominal (N_CH=3, HOLD=8, LOCK_FILT=16): pll_lock high sampled at edge E -> locked = 1 after E+17 and SEQ entered at E+18. Releases are rst_out = 3'b110 after E+26, 3'b100 after E+34, 3'b000 with ready = 1 after E+42.
- Glitchy lock: pll_lock high for 10 cycles, low for 1, then high -> no release before the filter's full 16-cycle count after the glitch; lock_loss_cnt stays 0.
- Lock loss in RUN: drop pll_lock -> all resets = 3'b111 and ready = 0 two edges later; lock_loss_cnt = 1. Re-lock -> the full nominal timeline repeats.
- Software request in RUN: pulse sw_rst_req for 1 cycle -> next edge rst_out = 3'b111; releases follow 8, 16 and 24 edges later; locked stays 1.
- Saturation and priority: with CNT_W=2, force 5 lock losses -> lock_loss_cnt = 3. Assert sw_rst_req in the same cycle lock_s falls -> WAIT is entered, not SEQ. Assert rst mid-SEQ -> full reset values on the next edge.
